// File: rtl/jx2_if_pc_stage_if.sv
// jx2_if_pc_stage_if: tile, redirect and decode signals of the fetch PC stage
// With JX2_IF_PERF_CNT_EN defined the bundle also carries the perf counters.
interface jx2_if_pc_stage_if;
  logic [63:0] icInPc;
  logic [47:0] icPcVal;
  logic [1:0]  icPcOK;
  logic [1:0]  icPcStep;
  logic        brTaken;
  logic [47:0] brAddr;
  logic        idValid;
  logic        idReady;
  logic [47:0] idOpWord;
  logic [1:0]  idOpLen;
  logic [47:0] idOpPc;
  logic        ifFault;
`ifdef JX2_IF_PERF_CNT_EN
  logic [31:0] ifCntOps;
  logic [31:0] ifCntHold;
  modport master (
    output icInPc, idValid, idOpWord, idOpLen, idOpPc, ifFault, ifCntOps, ifCntHold,
    input  icPcVal, icPcOK, icPcStep, brTaken, brAddr, idReady
  );
  modport slave (
    input  icInPc, idValid, idOpWord, idOpLen, idOpPc, ifFault, ifCntOps, ifCntHold,
    output icPcVal, icPcOK, icPcStep, brTaken, brAddr, idReady
  );
`else
  modport master (
    output icInPc, idValid, idOpWord, idOpLen, idOpPc, ifFault,
    input  icPcVal, icPcOK, icPcStep, brTaken, brAddr, idReady
  );
  modport slave (
    input  icInPc, idValid, idOpWord, idOpLen, idOpPc, ifFault,
    output icPcVal, icPcOK, icPcStep, brTaken, brAddr, idReady
  );
`endif
endinterface

// File: rtl/jx2_if_pc_stage.sv
// jx2_if_pc_stage: fetch PC owner feeding a 2-entry op queue toward decode
// Optional perf counters ifCntOps/ifCntHold are built when JX2_IF_PERF_CNT_EN is defined.
module jx2_if_pc_stage #(
  parameter logic [47:0] RESET_PC = 48'h0000_0000_0000
) (
  input logic clock,
  input logic reset,
  jx2_if_pc_stage_if.master bus
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [1:0] ST_OK = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b11;
  state_t state, stateNext;
  logic [47:0] pcReg, pcNext;
  logic [47:0] qWord [2];
  logic [1:0]  qLen [2];
  logic [47:0] qPc [2];
  logic [1:0]  count, countPop;
  logic pop, push, faultEv;
  assign bus.icInPc   = {16'h0, pcReg};
  assign bus.idValid  = count != 2'd0;
  assign bus.idOpWord = qWord[0];
  assign bus.idOpLen  = qLen[0];
  assign bus.idOpPc   = qPc[0];
  assign bus.ifFault  = state == FAULT;
  assign pop      = bus.idValid && bus.idReady;
  assign countPop = count - {1'b0, pop};
  always_comb begin
    push = state == RUN && bus.icPcOK == ST_OK && bus.icPcStep != 2'd0 &&
           (count != 2'd2 || pop) && !bus.brTaken;
    faultEv = state == RUN && (bus.icPcOK == ST_FAULT || (bus.icPcOK == ST_OK && bus.icPcStep == 2'd0));
    stateNext = bus.brTaken ? RUN : faultEv ? FAULT : state;
    pcNext = bus.brTaken ? {bus.brAddr[47:1], 1'b0} :
             push ? pcReg + {45'd0, bus.icPcStep, 1'b0} : pcReg;
  end
  // Pop shifts entry 1 down; a push then lands in the first free slot after the pop.
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      pcReg <= {RESET_PC[47:1], 1'b0};
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        qWord[i] <= '0;
        qLen[i]  <= '0;
        qPc[i]   <= '0;
      end
    end else begin
      state <= stateNext;
      pcReg <= pcNext;
      count <= bus.brTaken ? 2'd0 : countPop + {1'b0, push};
      if (pop) begin
        qWord[0] <= qWord[1];
        qLen[0]  <= qLen[1];
        qPc[0]   <= qPc[1];
      end
      if (push) begin
        qWord[countPop[0]] <= bus.icPcVal;
        qLen[countPop[0]]  <= bus.icPcStep;
        qPc[countPop[0]]   <= pcReg;
      end
    end
`ifdef JX2_IF_PERF_CNT_EN
  logic [31:0] cntOps, cntHold;
  assign bus.ifCntOps  = cntOps;
  assign bus.ifCntHold = cntHold;
  always_ff @(posedge clock)
    if (reset) begin
      cntOps  <= '0;
      cntHold <= '0;
    end else begin
      if (push && ~&cntOps) cntOps <= cntOps + 32'd1;
      if (state == RUN && bus.icPcOK != ST_OK && ~&cntHold) cntHold <= cntHold + 32'd1;
    end
`endif
endmodule

// File: tb/tb_jx2_if_pc_stage.sv
// tb_jx2_if_pc_stage: directed vector table plus reset corner sequence for jx2_if_pc_stage
module tb_jx2_if_pc_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int nComp = 0;
  int nFail = 0;
  always #5 clock = ~clock;
  jx2_if_pc_stage_if bus();
  jx2_if_pc_stage #(.RESET_PC(48'h0000_0000_1000)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0]  ok;
    logic [1:0]  step;
    logic [47:0] val;
    logic        rdy;
    logic        br;
    logic [47:0] brA;
    logic        eValid;
    logic [47:0] ePc;
    logic [1:0]  eLen;
    logic [47:0] eWord;
    logic [63:0] eInPc;
    logic        eFault;
  } vec_t;
  vec_t vt[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] ok, input logic [1:0] step, input logic [47:0] val,
                       input logic rdy, input logic br, input logic [47:0] brA);
    bus.icPcOK = ok;
    bus.icPcStep = step;
    bus.icPcVal = val;
    bus.idReady = rdy;
    bus.brTaken = br;
    bus.brAddr = brA;
  endtask
  initial begin
    vt.push_back('{2'b01, 2'd1, 48'hA1, 1'b1, 1'b0, 48'h0,    1'b1, 48'h1000, 2'd1, 48'hA1, 64'h1000 + 64'h2, 1'b0});
    vt.push_back('{2'b01, 2'd2, 48'hA2, 1'b1, 1'b0, 48'h0,    1'b1, 48'h1002, 2'd2, 48'hA2, 64'h1006, 1'b0});
    vt.push_back('{2'b01, 2'd3, 48'hA3, 1'b1, 1'b0, 48'h0,    1'b1, 48'h1006, 2'd3, 48'hA3, 64'h100C, 1'b0});
    vt.push_back('{2'b00, 2'd0, 48'h0,  1'b1, 1'b0, 48'h0,    1'b0, 48'h0,    2'd0, 48'h0,  64'h100C, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hB1, 1'b0, 1'b0, 48'h0,    1'b1, 48'h100C, 2'd1, 48'hB1, 64'h100E, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hB2, 1'b0, 1'b0, 48'h0,    1'b1, 48'h100C, 2'd1, 48'hB1, 64'h1010, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hB3, 1'b0, 1'b0, 48'h0,    1'b1, 48'h100C, 2'd1, 48'hB1, 64'h1010, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hB3, 1'b0, 1'b0, 48'h0,    1'b1, 48'h100C, 2'd1, 48'hB1, 64'h1010, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hB3, 1'b1, 1'b0, 48'h0,    1'b1, 48'h100E, 2'd1, 48'hB2, 64'h1012, 1'b0});
    vt.push_back('{2'b10, 2'd0, 48'h0,  1'b1, 1'b0, 48'h0,    1'b1, 48'h1010, 2'd1, 48'hB3, 64'h1012, 1'b0});
    vt.push_back('{2'b10, 2'd0, 48'h0,  1'b1, 1'b0, 48'h0,    1'b0, 48'h0,    2'd0, 48'h0,  64'h1012, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hC1, 1'b1, 1'b1, 48'h2001, 1'b0, 48'h0,    2'd0, 48'h0,  64'h2000, 1'b0});
    vt.push_back('{2'b01, 2'd2, 48'hC2, 1'b0, 1'b0, 48'h0,    1'b1, 48'h2000, 2'd2, 48'hC2, 64'h2004, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hC3, 1'b0, 1'b0, 48'h0,    1'b1, 48'h2000, 2'd2, 48'hC2, 64'h2006, 1'b0});
    vt.push_back('{2'b01, 2'd1, 48'hC4, 1'b0, 1'b1, 48'h2FFC, 1'b0, 48'h0,    2'd0, 48'h0,  64'h2FFC, 1'b0});
    vt.push_back('{2'b01, 2'd2, 48'hD1, 1'b0, 1'b0, 48'h0,    1'b1, 48'h2FFC, 2'd2, 48'hD1, 64'h3000, 1'b0});
    vt.push_back('{2'b11, 2'd0, 48'h0,  1'b0, 1'b0, 48'h0,    1'b1, 48'h2FFC, 2'd2, 48'hD1, 64'h3000, 1'b1});
    vt.push_back('{2'b01, 2'd1, 48'hD2, 1'b1, 1'b0, 48'h0,    1'b0, 48'h0,    2'd0, 48'h0,  64'h3000, 1'b1});
    vt.push_back('{2'b01, 2'd1, 48'hD2, 1'b1, 1'b0, 48'h0,    1'b0, 48'h0,    2'd0, 48'h0,  64'h3000, 1'b1});
    vt.push_back('{2'b01, 2'd1, 48'hD2, 1'b1, 1'b1, 48'h4000, 1'b0, 48'h0,    2'd0, 48'h0,  64'h4000, 1'b0});
    vt.push_back('{2'b01, 2'd3, 48'hE1, 1'b1, 1'b0, 48'h0,    1'b1, 48'h4000, 2'd3, 48'hE1, 64'h4006, 1'b0});
    vt.push_back('{2'b01, 2'd0, 48'hE2, 1'b0, 1'b0, 48'h0,    1'b1, 48'h4000, 2'd3, 48'hE1, 64'h4006, 1'b1});
    vt.push_back('{2'b00, 2'd0, 48'h0,  1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 48'h0, 2'd0, 48'h0, 64'h0000_FFFF_FFFF_FFFE, 1'b0});
    vt.push_back('{2'b01, 2'd2, 48'hF1, 1'b1, 1'b0, 48'h0,    1'b1, 48'hFFFF_FFFF_FFFE, 2'd2, 48'hF1, 64'h2, 1'b0});
    vt.push_back('{2'b00, 2'd0, 48'h0,  1'b1, 1'b0, 48'h0,    1'b0, 48'h0,    2'd0, 48'h0,  64'h2, 1'b0});
    drive(2'b00, 2'd0, 48'h0, 1'b0, 1'b0, 48'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset.inPc", bus.icInPc, 64'h1000);
    chk("reset.valid", {63'd0, bus.idValid}, 64'd0);
    chk("reset.fault", {63'd0, bus.ifFault}, 64'd0);
    chk("reset.opPc", {16'd0, bus.idOpPc}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ok, vt[i].step, vt[i].val, vt[i].rdy, vt[i].br, vt[i].brA);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.valid", i), {63'd0, bus.idValid}, {63'd0, vt[i].eValid});
      chk($sformatf("v%0d.inPc", i), bus.icInPc, vt[i].eInPc);
      chk($sformatf("v%0d.fault", i), {63'd0, bus.ifFault}, {63'd0, vt[i].eFault});
      if (vt[i].eValid) begin
        chk($sformatf("v%0d.opPc", i), {16'd0, bus.idOpPc}, {16'd0, vt[i].ePc});
        chk($sformatf("v%0d.opLen", i), {62'd0, bus.idOpLen}, {62'd0, vt[i].eLen});
        chk($sformatf("v%0d.opWord", i), {16'd0, bus.idOpWord}, {16'd0, vt[i].eWord});
      end
    end
    drive(2'b01, 2'd1, 48'h51, 1'b0, 1'b0, 48'h0);
    @(posedge clock);
    #1;
    chk("mid.valid", {63'd0, bus.idValid}, 64'd1);
    chk("mid.opPc", {16'd0, bus.idOpPc}, 64'h2);
    chk("mid.inPc", bus.icInPc, 64'h4);
    drive(2'b11, 2'd0, 48'h0, 1'b0, 1'b0, 48'h0);
    @(posedge clock);
    #1;
    chk("mid.fault", {63'd0, bus.ifFault}, 64'd1);
    drive(2'b01, 2'd1, 48'h52, 1'b0, 1'b0, 48'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst2.inPc", bus.icInPc, 64'h1000);
    chk("rst2.valid", {63'd0, bus.idValid}, 64'd0);
    chk("rst2.fault", {63'd0, bus.ifFault}, 64'd0);
    chk("rst2.opWord", {16'd0, bus.idOpWord}, 64'd0);
    chk("rst2.opLen", {62'd0, bus.idOpLen}, 64'd0);
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end
endmodule
